// File: rtl/fifo_word_reader_pkg.sv
// Shared widths, lane helpers and FSM encoding for the FIFO byte-to-word reader.
package fifo_rd_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    OUT     = 2'd2
  } rd_state_e;

  function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [LANE_W-1:0] lane);
    return WORD_BYTES'(1) << lane;
  endfunction

endpackage

// File: rtl/fifo_word_reader_if.sv
// FIFO-side and word-stream-side signals of the reader, bundled for port use.
interface fifo_word_reader_if;
  import fifo_rd_pkg::*;

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_wr;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_rd;
  logic              flush;
  logic [WORD_W-1:0] m_data;
  logic [WORD_BYTES-1:0] m_keep;
  logic              m_valid;
  logic              m_ready;

  // Reader view.
  modport master (
    input  fifo_empty, fifo_full, fifo_wr, fifo_dout, flush, m_ready,
    output fifo_rd, m_data, m_keep, m_valid
  );

  // Environment view: FIFO plus word consumer.
  modport slave (
    output fifo_empty, fifo_full, fifo_wr, fifo_dout, flush, m_ready,
    input  fifo_rd, m_data, m_keep, m_valid
  );

endinterface

// File: rtl/fifo_word_reader.sv
// Pulls bytes from a registered-output sync FIFO and packs them little-endian
// into 32-bit words, with an optional flush to emit a partial word.
module fifo_word_reader
  import fifo_rd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fifo_word_reader_if.master bus
);

  rd_state_e             state_q, state_d;
  logic [LANE_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic [WORD_BYTES-1:0] keep_q, keep_d;

  logic rd_req;
  logic wr_wins;
  logic rd_acc;

  // The FIFO services a same-cycle write instead of our read, so a colliding
  // read is simply retried from FETCH on the next cycle.
  always_comb begin
    rd_req  = (state_q == FETCH) && !bus.fifo_empty;
    wr_wins = bus.fifo_wr && !bus.fifo_full;
    rd_acc  = rd_req && !bus.fifo_empty && !wr_wins;

    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    keep_d     = keep_q;

    case (state_q)
      FETCH: begin
        if (rd_acc) begin
          state_d = CAPTURE;
        end else if (bus.flush && (byte_cnt_q != '0)) begin
          state_d = OUT;
        end
      end

      CAPTURE: begin
        // FIFO read data is registered: it is valid the cycle after the read.
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (byte_cnt_q == LANE_W'(k)) begin
            data_d[k*BYTE_W +: BYTE_W] = bus.fifo_dout;
          end
        end
        keep_d     = keep_q | lane_mask(byte_cnt_q);
        byte_cnt_d = byte_cnt_q + LANE_W'(1);
        state_d    = (byte_cnt_q == LAST_LANE) ? OUT : FETCH;
      end

      OUT: begin
        if (bus.m_ready) begin
          state_d    = FETCH;
          byte_cnt_d = '0;
          data_d     = '0;
          keep_d     = '0;
        end
      end

      default: begin
        state_d    = FETCH;
        byte_cnt_d = '0;
        data_d     = '0;
        keep_d     = '0;
      end
    endcase
  end

  // Word contents are cleared on reset as well, so a reset always discards a
  // partially collected word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      byte_cnt_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
    end
  end

  assign bus.fifo_rd = rd_req;
  assign bus.m_valid = (state_q == OUT);
  assign bus.m_data  = data_q;
  assign bus.m_keep  = keep_q;

endmodule
